// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory controller: sized loads/stores with extension, error
// reporting, fixed-latency response pipeline and a post-reset clear sequencer.
module data_mem_ctrl #(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = 64,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFS_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CMP_W = ((ADDR_W > 64) ? ADDR_W : 64) + 1;
  localparam logic [CMP_W-1:0] MEM_BYTES = CMP_W'(DEPTH) * CMP_W'(BYTES);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        clr_cnt;
  logic [DATA_W-1:0]       mem [DEPTH];

  logic [OFS_W-1:0]        ofs;
  logic [IDX_W-1:0]        idx;
  logic [3:0]              nbytes;
  logic                    req_err;
  logic                    accept;
  logic                    do_store;
  logic [DATA_W-1:0]       wmask;
  logic [DATA_W-1:0]       wshift;
  logic [DATA_W-1:0]       rd_word;

  logic                    vld_p   [READ_LAT];
  logic                    err_p   [READ_LAT];
  logic [DATA_W-1:0]       rdata_p [READ_LAT];

  // Contiguous low mask covering an access of (1 << size) bytes.
  function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] size);
    int bits;
    bits = 8 << size;
    return ~({DATA_W{1'b1}} << bits);
  endfunction

  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] word,
                                                 input logic [OFS_W-1:0]  o,
                                                 input logic [1:0]        size,
                                                 input logic              uns);
    logic [DATA_W-1:0] sh, m, val;
    sh  = word >> {o, 3'b000};
    m   = size_mask(size);
    val = sh & m;
    // Sign bit is the top bit of the lane mask; a full-width mask extends nothing.
    if (!uns && (~m != '0) && ((sh & m & ~(m >> 1)) != '0))
      val = val | ~m;
    return val;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == S_INIT && clr_cnt == IDX_W'(DEPTH - 1))
      state_nxt = S_RUN;
  end

  always_comb begin
    req_ready = (state == S_RUN);
    init_done = (state == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst)                  clr_cnt <= '0;
    else if (state == S_INIT) clr_cnt <= clr_cnt + 1'b1;
  end

  always_comb begin
    ofs      = req_addr[OFS_W-1:0];
    idx      = req_addr[OFS_W +: IDX_W];
    nbytes   = 4'd1 << req_size;
    req_err  = (int'(nbytes) > BYTES)
             || ((4'(ofs) & (nbytes - 4'd1)) != 4'd0)
             || (CMP_W'(req_addr) >= MEM_BYTES);
    accept   = req_valid && req_ready;
    do_store = accept && req_we && !req_err && !rst;
    wmask    = size_mask(req_size) << {ofs, 3'b000};
    wshift   = req_wdata << {ofs, 3'b000};
    rd_word  = mem[idx];
  end

  always_ff @(posedge clk) begin
    if (state == S_INIT)
      mem[clr_cnt] <= '0;
    else if (do_store)
      mem[idx] <= (mem[idx] & ~wmask) | (wshift & wmask);
  end

  // Stage p0 captures the response at accept; later stages only delay it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LAT; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= accept;
      for (int i = 1; i < READ_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    err_p[0]   <= req_err;
    rdata_p[0] <= (req_we || req_err) ? '0
                : load_ext(rd_word, ofs, req_size, req_unsigned);
    for (int i = 1; i < READ_LAT; i++) begin
      err_p[i]   <= err_p[i-1];
      rdata_p[i] <= rdata_p[i-1];
    end
  end

  always_comb begin
    rsp_valid = vld_p[READ_LAT-1];
    rsp_err   = vld_p[READ_LAT-1] && err_p[READ_LAT-1];
    rsp_rdata = vld_p[READ_LAT-1] ? rdata_p[READ_LAT-1] : '0;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomised scoreboard bench for data_mem_ctrl (64-bit, latency 3) plus directed
// checks on a 32-bit, latency-1 instance.
module tb_data_mem_ctrl;

  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int LAT   = 3;
  localparam int NB    = DW / 8;
  localparam int MEMB  = DEPTH * NB;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [63:0]   req_addr;
  logic [1:0]    req_size;
  logic [63:0]   req_wdata;
  logic          rsp_valid, rsp_err, init_done;
  logic [63:0]   rsp_rdata;

  logic          u_req_valid, u_req_ready, u_req_we, u_req_unsigned;
  logic [31:0]   u_req_addr;
  logic [1:0]    u_req_size;
  logic [31:0]   u_req_wdata;
  logic          u_rsp_valid, u_rsp_err, u_init_done;
  logic [31:0]   u_rsp_rdata;

  int            checks = 0;
  int            errors = 0;
  longint        cyc = 0;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    longint      due;
  } exp_t;

  exp_t          sbq[$];
  exp_t          mon_e;
  logic [7:0]    ref_mem [MEMB];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(64), .READ_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .init_done(init_done));

  data_mem_ctrl #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .READ_LAT(1)) u32 (
    .clk(clk), .rst(rst), .req_valid(u_req_valid), .req_ready(u_req_ready),
    .req_we(u_req_we), .req_addr(u_req_addr), .req_size(u_req_size),
    .req_unsigned(u_req_unsigned), .req_wdata(u_req_wdata), .rsp_valid(u_rsp_valid),
    .rsp_rdata(u_rsp_rdata), .rsp_err(u_rsp_err), .init_done(u_init_done));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: flat byte array, little-endian, plain arithmetic.
  task automatic issue(input logic we, input logic [63:0] addr, input logic [1:0] size,
                       input logic uns, input logic [63:0] wdata);
    exp_t        e;
    int          nb;
    int          base;
    logic [63:0] v;
    nb      = 1 << size;
    e.err   = (nb > NB) || ((addr % 64'(nb)) != 64'd0) || (addr >= 64'(MEMB));
    e.rdata = '0;
    if (!e.err) begin
      base = int'(addr);
      if (we) begin
        for (int i = 0; i < nb; i++) ref_mem[base + i] = wdata[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[base + i];
        if (!uns && nb < 8 && v[8*nb-1])
          for (int j = nb; j < 8; j++) v[8*j +: 8] = 8'hFF;
        e.rdata = v;
      end
    end
    e.due = cyc + LAT;
    sbq.push_back(e);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    req_valid   = 1'b0;
    u_req_valid = 1'b0;
    rst         = 1'b1;
    for (int i = sbq.size() - 1; i >= 0; i--)
      if (sbq[i].due > cyc) sbq.delete(i);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < MEMB; i++) ref_mem[i] = 8'h00;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    for (int k = 1; k <= DEPTH; k++) begin
      @(posedge clk); #1;
      check($sformatf("init_done_k%0d", k), 64'(init_done), 64'(k == DEPTH));
      check($sformatf("req_ready_k%0d", k), 64'(req_ready), 64'(k == DEPTH));
    end
    check("u32_init_done", 64'(u_init_done), 64'd1);
  endtask

  task automatic u_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
    u_req_valid    = 1'b1;
    u_req_we       = we;
    u_req_addr     = addr;
    u_req_size     = size;
    u_req_unsigned = uns;
    u_req_wdata    = wdata;
    @(posedge clk); #1;
    u_req_valid = 1'b0;
    check($sformatf("u32_valid_%h", addr), 64'(u_rsp_valid), 64'd1);
    check($sformatf("u32_rdata_%h", addr), 64'(u_rsp_rdata), 64'(exp_rdata));
    check($sformatf("u32_err_%h", addr), 64'(u_rsp_err), 64'(exp_err));
  endtask

  // Monitor: pops one expectation per response and flags missing or extra pulses.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 required 0 (cycle %0d)", cyc);
      end else begin
        mon_e = sbq.pop_front();
        check("rsp_rdata", rsp_rdata, mon_e.rdata);
        check("rsp_err", 64'(rsp_err), 64'(mon_e.err));
        check("rsp_cycle", 64'(cyc), 64'(mon_e.due));
      end
    end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      mon_e = sbq.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_rsp: got rsp_valid=0 required 1 (due cycle %0d, now %0d)",
               mon_e.due, cyc);
    end
  end

  task automatic random_ops(input int n);
    logic [63:0] addr;
    logic [1:0]  size;
    int          r;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        size = 2'($urandom_range(0, 3));
        addr = 64'($urandom_range(0, MEMB + 15));
        r    = $urandom_range(0, 15);
        if (r < 11) addr = addr & ~(64'(1 << size) - 64'd1);
        if (r == 15) addr = addr | (64'd1 << $urandom_range(7, 63));
        issue(1'($urandom_range(0, 1)), addr, size, 1'($urandom_range(0, 1)),
              {$urandom, $urandom});
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0;
    u_req_valid = 1'b0; u_req_we = 1'b0; u_req_addr = '0; u_req_size = '0;
    u_req_unsigned = 1'b0; u_req_wdata = '0;
    @(posedge clk); #1;
    do_reset();

    // 32-bit instance: illegal double, extension, out of range.
    u_req(1'b1, 32'h8,  2'd2, 1'b0, 32'h89ABCDEF, 32'h0, 1'b0);
    u_req(1'b0, 32'h8,  2'd3, 1'b0, 32'h0, 32'h0, 1'b1);
    u_req(1'b0, 32'hA,  2'd1, 1'b0, 32'h0, 32'hFFFF89AB, 1'b0);
    u_req(1'b0, 32'hB,  2'd0, 1'b1, 32'h0, 32'h00000089, 1'b0);
    u_req(1'b0, 32'h8,  2'd2, 1'b0, 32'h0, 32'h89ABCDEF, 1'b0);
    u_req(1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1);

    issue(1'b0, 64'h78, 2'd3, 1'b0, 64'h0);
    issue(1'b1, 64'h10, 2'd3, 1'b0, 64'h1122334455667788);
    issue(1'b1, 64'h13, 2'd0, 1'b0, 64'hAA);
    issue(1'b0, 64'h10, 2'd3, 1'b0, 64'h0);
    issue(1'b0, 64'h13, 2'd0, 1'b0, 64'h0);
    issue(1'b0, 64'h13, 2'd0, 1'b1, 64'h0);
    issue(1'b0, 64'h12, 2'd1, 1'b0, 64'h0);
    issue(1'b1, 64'h12, 2'd2, 1'b0, 64'hDEADBEEF);
    issue(1'b0, 64'h10, 2'd3, 1'b0, 64'h0);
    issue(1'b0, 64'h80, 2'd3, 1'b0, 64'h0);
    issue(1'b0, 64'h1_0000_0010, 2'd3, 1'b0, 64'h0);
    idle(LAT + 1);

    issue(1'b1, 64'h20, 2'd3, 1'b0, 64'hCAFEF00D12345678);
    issue(1'b0, 64'h20, 2'd3, 1'b0, 64'h0);
    issue(1'b0, 64'h28, 2'd3, 1'b0, 64'h0);
    issue(1'b1, 64'h28, 2'd2, 1'b0, 64'h0BADC0DE);
    idle(LAT + 1);

    random_ops(400);
    idle(LAT + 2);

    issue(1'b1, 64'h30, 2'd3, 1'b0, 64'h0123456789ABCDEF);
    idle(LAT + 1);
    issue(1'b0, 64'h30, 2'd3, 1'b0, 64'h0);
    issue(1'b0, 64'h38, 2'd3, 1'b0, 64'h0);
    do_reset();
    issue(1'b0, 64'h30, 2'd3, 1'b0, 64'h0);
    random_ops(60);
    idle(LAT + 2);

    check("sb_drained", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
